io_input_irq_ctrl: RTL and testbench
====================================

// Module: io_input_irq_ctrl
// PURPOSE
//  Input-side I/O stage that sits directly upstream of the 16-bit MIPS core.
//  It buffers words from an external producer in a small FIFO and presents
//  them one at a time on the core's data_in bus. Each new word is announced
//  with a one-cycle interrupt pulse to the jump control block. The word is
//  then held stable for a fixed window so the ISR can read it.
// PARAMETERS
//  DATA_W       16  width of the data word
//  DEPTH         4  FIFO depth in words; power of two, >= 2
//  HOLD_CYCLES   8  cycles data_in is held after the interrupt pulse; >= 1
//  IRQ_GAP       4  idle cycles forced between successive pulses; >= 1
// PORTS
//  clk         in   1                  system clock; all logic on posedge
//  reset       in   1                  synchronous, active-low reset
//  ext_data    in   DATA_W             word from the external producer
//  ext_valid   in   1                  producer has a word on ext_data
//  ext_ready   out  1                  FIFO can accept a word this cycle
//  irq_enable  in   1                  allows a new delivery to start
//  data_in     out  DATA_W             word presented to the core's data_in
//  interrupt   out  1                  one-cycle pulse to the core's interrupt
//  fifo_count  out  $clog2(DEPTH)+1    words currently stored
//  overflow    out  1                  sticky: producer offered a word while full
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - state=IDLE; rd_ptr=wr_ptr=0; fifo_count=0; data_in=0; interrupt=0;
//    overflow=0; hold/gap counter=0.
//  - ext_ready=0 while reset is low.
//  - Reset mid-operation aborts any delivery and discards FIFO contents.
//  FIFO:
//  - ext_ready = reset && (fifo_count < DEPTH); combinational, no full bypass.
//  - Push on posedge when ext_valid && ext_ready: mem[wr_ptr]<=ext_data, wr_ptr++.
//  - Pop happens only in LOAD: rd_ptr++.
//  - Pointers wrap modulo DEPTH. fifo_count = count + push - pop, so a
//    simultaneous push and pop leaves it unchanged.
//  - A word offered while full is dropped (ext_ready=0) and overflow<=1.
//    overflow clears only on reset.
//  FSM (Moore outputs; one transition per posedge):
//  - IDLE : interrupt=0; data_in keeps its last word.
//           Go to LOAD if fifo_count!=0 && irq_enable.
//  - LOAD : data_in<=mem[rd_ptr]; pop; go to IRQ.
//  - IRQ  : interrupt=1 for exactly this cycle; cnt<=HOLD_CYCLES-1; go to HOLD.
//  - HOLD : data_in stable; cnt-- each cycle. At cnt==0: cnt<=IRQ_GAP-1, go to GAP.
//  - GAP  : interrupt=0; cnt-- each cycle. At cnt==0: go to IDLE.
//  Timing and conditions:
//  - irq_enable is sampled in IDLE only. Dropping it mid-sequence does not
//    cut the sequence short.
//  - Latency from a push edge E into an empty FIFO (irq_enable=1):
//    LOAD at E+1; data_in updated and interrupt high at E+2.
//  - data_in changes only on the LOAD->IRQ edge, so it is stable for
//    1+HOLD_CYCLES+IRQ_GAP cycles minimum.
//  - Back-to-back pulse spacing = 2+HOLD_CYCLES+IRQ_GAP+1 cycles when the
//    FIFO stays non-empty (the +1 is the IDLE cycle).
//  - Counter width is $clog2(max(HOLD_CYCLES,IRQ_GAP))+1; unsigned; never
//    decremented below 0.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with ext_valid=1 -> ext_ready=0,
//    fifo_count=0, data_in=0, interrupt=0, overflow=0.
//  - Single word: push 16'hA5A5 at edge E -> data_in=A5A5 and interrupt=1
//    at E+2 only; data_in unchanged through E+14 (defaults).
//  - Burst fill: push 5 words 1..5 on consecutive cycles with irq_enable=0
//    -> fifo_count=4, ext_ready=0, word 5 dropped, overflow=1.
//  - Drain: then raise irq_enable -> data_in 1,2,3,4 in order, pulses 15
//    cycles apart; fifo_count ends at 0 and no 5th pulse occurs.
//  - Concurrent: FIFO full while in LOAD with ext_valid=1 -> push refused
//    that cycle; push accepted next cycle; fifo_count returns to 4.
//  - Abort: assert reset=0 during HOLD with 2 words queued -> next edge:
//    state IDLE, fifo_count=0, data_in=0, no further interrupt pulses.

Source files
------------

// File: rtl/io_input_irq_ctrl.sv
// io_input_irq_ctrl
//   Input-side I/O stage in front of the 16-bit MIPS core. Words from an
//   external producer are buffered in a small FIFO. Each word is delivered
//   to the core's data_in bus and announced with a one-cycle interrupt
//   pulse. The word is then held for a fixed window so the ISR can read it,
//   and a forced idle gap follows before the next delivery can begin.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous, active-low reset
//   ext_data    in   DATA_W   word from the external producer
//   ext_valid   in   producer has a word on ext_data
//   ext_ready   out  FIFO can accept a word this cycle
//   irq_enable  in   allows a new delivery to start (sampled in IDLE only)
//   data_in     out  DATA_W   word presented to the core
//   interrupt   out  one-cycle pulse announcing a new word
//   fifo_count  out  words currently stored
//   overflow    out  sticky, producer offered a word while full
module io_input_irq_ctrl #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int IRQ_GAP     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        ext_data,
   input  logic                     ext_valid,
   output logic                     ext_ready,
   input  logic                     irq_enable,
   output logic [DATA_W-1:0]        data_in,
   output logic                     interrupt,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_MAXV = (HOLD_CYCLES > IRQ_GAP) ? HOLD_CYCLES : IRQ_GAP;
   localparam int CNT_W    = $clog2(CNT_MAXV) + 1;
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(IRQ_GAP - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      IRQ  = 3'd2,
      HOLD = 3'd3,
      GAP  = 3'd4
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  cnt;
   state_t            state;
   state_t            state_nxt;

   // count never exceeds DEPTH (a power of two), so its MSB alone flags full
   assign full      = fifo_count[PTR_W];
   assign ext_ready = reset && !full;
   assign push      = ext_valid && ext_ready;
   assign pop       = (state == LOAD);

   // FIFO storage: data only, left unreset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= ext_data;
      end
   end

   // FIFO control: pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         // with reset high, a refused offer can only mean the FIFO is full
         if (ext_valid && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (fifo_count != '0 && irq_enable) state_nxt = LOAD;
         LOAD: state_nxt = IRQ;
         IRQ:  state_nxt = HOLD;
         HOLD: if (cnt == '0) state_nxt = GAP;
         GAP:  if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM Moore outputs
   always_comb begin
      interrupt = (state == IRQ);
   end

   // Delivered word and hold/gap window counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_in <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            LOAD: data_in <= mem[rd_ptr];
            IRQ:  cnt <= HOLD_INIT;
            HOLD: begin
               if (cnt == '0) begin
                  cnt <= GAP_INIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_io_input_irq_ctrl.sv
// tb_io_input_irq_ctrl
//   Bench for io_input_irq_ctrl. A reference model tracks the FIFO as a
//   queue and each delivery as a start timestamp: the word is popped one
//   edge after the start decision, the pulse follows it, and the block is
//   free again 2+HOLD_CYCLES+IRQ_GAP edges after the decision.
module tb_io_input_irq_ctrl;

   localparam int DATA_W  = 16;
   localparam int DEPTH   = 4;
   localparam int H       = 8;
   localparam int G       = 4;
   localparam int SPACING = 2 + H + G + 1;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [DATA_W-1:0]      ext_data = '0;
   logic                   ext_valid = 1'b0;
   logic                   ext_ready;
   logic                   irq_enable = 1'b0;
   logic [DATA_W-1:0]      data_in;
   logic                   interrupt;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   overflow;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model
   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] m_data  = '0;
   bit                m_ovf   = 1'b0;
   bit                m_busy  = 1'b0;
   int                m_start = 0;
   int                cyc     = 0;

   always #5 clk = ~clk;

   io_input_irq_ctrl #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(H), .IRQ_GAP(G)
   ) dut (
      .clk(clk), .reset(reset), .ext_data(ext_data), .ext_valid(ext_valid),
      .ext_ready(ext_ready), .irq_enable(irq_enable), .data_in(data_in),
      .interrupt(interrupt), .fifo_count(fifo_count), .overflow(overflow)
   );

   task automatic model_edge();
      int n;
      int sz;
      n  = cyc + 1;
      sz = q.size();
      if (!reset) begin
         q.delete();
         m_data = '0;
         m_ovf  = 1'b0;
         m_busy = 1'b0;
      end else begin
         if (m_busy) begin
            if (n == m_start + 1) m_data = q.pop_front();
            if (n == m_start + 2 + H + G) m_busy = 1'b0;
         end else if (sz != 0 && irq_enable) begin
            m_busy  = 1'b1;
            m_start = n;
         end
         if (ext_valid) begin
            if (sz < DEPTH) q.push_back(ext_data);
            else m_ovf = 1'b1;
         end
      end
      cyc = n;
   endtask

   function automatic bit m_irq();
      return m_busy && (cyc == m_start + 1);
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; ext_valid = 1'b1; ext_data = 16'hFFFF; irq_enable = 1'b1;
      repeat (3) step();
      n_checks++; if (ext_ready !== 1'b0) $display("FAIL reset_ext_ready got %b exp 0", ext_ready); else n_pass++;
      n_checks++; if (fifo_count !== '0) $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); else n_pass++;
      n_checks++; if (data_in !== '0) $display("FAIL reset_data_in got %h exp 0000", data_in); else n_pass++;
      n_checks++; if (interrupt !== 1'b0) $display("FAIL reset_interrupt got %b exp 0", interrupt); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
      ext_valid = 1'b0; reset = 1'b1;
      step();
   endtask

   task automatic test_single_word();
      logic [DATA_W-1:0] exp_d;
      irq_enable = 1'b1; ext_data = 16'hA5A5; ext_valid = 1'b1;
      step();
      ext_valid = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         step();
         exp_d = (k >= 2) ? 16'hA5A5 : 16'h0000;
         n_checks++; if (interrupt !== (k == 2)) $display("FAIL single_irq E+%0d got %b exp %b", k, interrupt, (k == 2)); else n_pass++;
         n_checks++; if (data_in !== exp_d) $display("FAIL single_data E+%0d got %h exp %h", k, data_in, exp_d); else n_pass++;
      end
      n_checks++; if (fifo_count !== '0) $display("FAIL single_count got %0d exp 0", fifo_count); else n_pass++;
      step();
   endtask

   task automatic test_burst_drain();
      int t_prev;
      int pulses;
      logic [DATA_W-1:0] exp_d;
      irq_enable = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         ext_data = DATA_W'(i); ext_valid = 1'b1;
         step();
      end
      ext_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL burst_count got %0d exp 4", fifo_count); else n_pass++;
      n_checks++; if (ext_ready !== 1'b0) $display("FAIL burst_ready got %b exp 0", ext_ready); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL burst_overflow got %b exp 1", overflow); else n_pass++;
      irq_enable = 1'b1;
      t_prev = -1; pulses = 0;
      for (int k = 0; k < 80; k++) begin
         step();
         if (interrupt === 1'b1) begin
            pulses++;
            exp_d = DATA_W'(pulses);
            n_checks++; if (data_in !== exp_d) $display("FAIL drain_data pulse %0d got %h exp %h", pulses, data_in, exp_d); else n_pass++;
            if (t_prev >= 0) begin
               n_checks++; if (cyc - t_prev != SPACING) $display("FAIL drain_spacing got %0d exp %0d", cyc - t_prev, SPACING); else n_pass++;
            end
            t_prev = cyc;
         end
      end
      n_checks++; if (pulses != 4) $display("FAIL drain_pulses got %0d exp 4", pulses); else n_pass++;
      n_checks++; if (fifo_count !== '0) $display("FAIL drain_count got %0d exp 0", fifo_count); else n_pass++;
      irq_enable = 1'b0;
   endtask

   task automatic test_concurrent();
      for (int i = 0; i < 4; i++) begin
         ext_data = 16'h0010 + DATA_W'(i); ext_valid = 1'b1;
         step();
      end
      ext_data = 16'h0020; ext_valid = 1'b1; irq_enable = 1'b1;
      step();
      n_checks++; if (ext_ready !== 1'b0) $display("FAIL conc_ready_load got %b exp 0", ext_ready); else n_pass++;
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL conc_count_load got %0d exp 4", fifo_count); else n_pass++;
      step();
      n_checks++; if (fifo_count !== 3'd3) $display("FAIL conc_count_pop got %0d exp 3", fifo_count); else n_pass++;
      n_checks++; if (data_in !== 16'h0010) $display("FAIL conc_data got %h exp 0010", data_in); else n_pass++;
      n_checks++; if (interrupt !== 1'b1) $display("FAIL conc_irq got %b exp 1", interrupt); else n_pass++;
      step();
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL conc_count_refill got %0d exp 4", fifo_count); else n_pass++;
      ext_valid = 1'b0; irq_enable = 1'b0;
      for (int k = 0; k < 30 && m_busy; k++) step();
   endtask

   task automatic test_abort();
      bit seen;
      int extra;
      reset = 1'b0;
      step();
      reset = 1'b1; irq_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ext_data = 16'h0031 + DATA_W'(i); ext_valid = 1'b1;
         step();
      end
      ext_valid = 1'b0; irq_enable = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (interrupt === 1'b1) seen = 1'b1;
      end
      n_checks++; if (!seen) $display("FAIL abort_first_irq got none exp pulse within 10 cycles"); else n_pass++;
      step(); step();
      n_checks++; if (fifo_count !== 3'd2) $display("FAIL abort_count_hold got %0d exp 2", fifo_count); else n_pass++;
      reset = 1'b0;
      step();
      n_checks++; if (fifo_count !== '0) $display("FAIL abort_count got %0d exp 0", fifo_count); else n_pass++;
      n_checks++; if (data_in !== '0) $display("FAIL abort_data got %h exp 0000", data_in); else n_pass++;
      n_checks++; if (interrupt !== 1'b0) $display("FAIL abort_irq got %b exp 0", interrupt); else n_pass++;
      n_checks++; if (ext_ready !== 1'b0) $display("FAIL abort_ready got %b exp 0", ext_ready); else n_pass++;
      reset = 1'b1;
      extra = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (interrupt === 1'b1) extra++;
      end
      n_checks++; if (extra != 0) $display("FAIL abort_no_pulse got %0d exp 0", extra); else n_pass++;
   endtask

   task automatic test_random();
      logic exp_rdy;
      for (int k = 0; k < 800; k++) begin
         ext_valid  = ($urandom_range(0, 99) < 60);
         ext_data   = DATA_W'($urandom);
         irq_enable = ($urandom_range(0, 99) < 70);
         reset      = ($urandom_range(0, 199) != 0);
         step();
         exp_rdy = reset && (q.size() < DEPTH);
         n_checks++; if (data_in !== m_data) $display("FAIL rand_data cyc %0d got %h exp %h", cyc, data_in, m_data); else n_pass++;
         n_checks++; if (interrupt !== m_irq()) $display("FAIL rand_irq cyc %0d got %b exp %b", cyc, interrupt, m_irq()); else n_pass++;
         n_checks++; if (int'(fifo_count) != q.size() || $isunknown(fifo_count)) $display("FAIL rand_count cyc %0d got %0d exp %0d", cyc, fifo_count, q.size()); else n_pass++;
         n_checks++; if (overflow !== m_ovf) $display("FAIL rand_overflow cyc %0d got %b exp %b", cyc, overflow, m_ovf); else n_pass++;
         n_checks++; if (ext_ready !== exp_rdy) $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, ext_ready, exp_rdy); else n_pass++;
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single_word();
      test_burst_drain();
      test_concurrent();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
